// File: rtl/ttl_bus_reader.sv
// Receive side of the shared 4-bit TTL bus: samples the bus while both active-low load
// enables are low, queues the samples in a small FIFO and hands them out over valid/ready.
module ttl_bus_reader #(
  parameter int WIDTH        = 4,
  parameter int DEPTH        = 4,
  parameter bit CAPTURE_EDGE = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           d,
  input  logic                       e1,
  input  logic                       e2,
  output logic [WIDTH-1:0]           q,
  output logic                       q_valid,
  input  logic                       q_ready,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ovf,
  input  logic                       ovf_clr
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_prev_strobe;
  logic             r_ovf;

  logic w_strobe;
  logic w_cap;
  logic w_valid;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_strobe = ~e1 & ~e2;
  assign w_cap    = CAPTURE_EDGE ? (w_strobe & ~r_prev_strobe) : w_strobe;
  assign w_valid  = (r_count != '0);
  assign w_full   = (r_count == FULL_COUNT);
  assign w_pop    = w_valid & q_ready;
  // A full FIFO still accepts a capture when the head leaves in the same cycle.
  assign w_push   = w_cap & (~w_full | w_pop);
  assign w_drop   = w_cap & w_full & ~w_pop;

  // Storage is deliberately left out of reset; only pointers decide what is visible.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_prev_strobe <= 1'b0;
      r_ovf         <= 1'b0;
    end else begin
      r_prev_strobe <= w_strobe;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign q       = w_valid ? r_mem[r_rd_ptr] : '0;
  assign q_valid = w_valid;
  assign full    = w_full;
  assign count   = r_count;
  assign ovf     = r_ovf;

endmodule
